// File: rtl/multiply_add_unit.sv
// multiply_add_unit: iterative shift-and-add unit computing
// result = mult_a * mult_b + add_c. It processes one multiplier bit per cycle,
// least significant bit first. It uses a level-enable request and a valid
// signal that stays high until the request is dropped.
module multiply_add_unit #(
  parameter int WORD_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [WORD_WIDTH-1:0]     mult_a,
  input  logic [WORD_WIDTH-1:0]     mult_b,
  input  logic [WORD_WIDTH-1:0]     add_c,
  output logic                      busy,
  output logic                      valid,
  output logic [2*WORD_WIDTH-1:0]   result
);

  localparam int RW = 2 * WORD_WIDTH;
  localparam int CW = $clog2(WORD_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                  state_q,  state_d;
  logic [RW-1:0]           a_sh_q,   a_sh_d;
  logic [WORD_WIDTH-1:0]   b_sh_q,   b_sh_d;
  logic [RW-1:0]           acc_q,    acc_d;
  logic [CW-1:0]           cnt_q,    cnt_d;
  logic [RW-1:0]           result_q, result_d;
  logic [RW-1:0]           acc_sum;

  // Next-state and datapath update for the IDLE -> CALC -> DONE sequence.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    acc_sum  = acc_q + (b_sh_q[0] ? a_sh_q : '0);

    unique case (state_q)
      IDLE: begin
        if (enable) begin
          a_sh_d  = {{WORD_WIDTH{1'b0}}, mult_a};
          b_sh_d  = mult_b;
          acc_d   = {{WORD_WIDTH{1'b0}}, add_c};
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d  = acc_sum;
        a_sh_d = a_sh_q << 1;
        b_sh_d = b_sh_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        // The last multiplier bit is handled here, so this cycle's add goes into result.
        if (cnt_q == CW'(WORD_WIDTH - 1)) begin
          result_d = acc_sum;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (!enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; a reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the pre-edge values.
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // The status outputs are decoded from the state register, so they carry no extra delay.
  always_comb begin
    busy   = (state_q != IDLE);
    valid  = (state_q == DONE);
    result = result_q;
  end

endmodule

// File: tb/tb_multiply_add_unit.sv
// tb_multiply_add_unit: directed test of multiply_add_unit with WORD_WIDTH=8.
// Each check compares an observed output against a hand-computed value.
module tb_multiply_add_unit;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [7:0]  mult_a;
  logic [7:0]  mult_b;
  logic [7:0]  add_c;
  logic        busy;
  logic        valid;
  logic [15:0] result;

  int pass_cnt  = 0;
  int total_cnt = 0;

  multiply_add_unit #(.WORD_WIDTH(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .mult_a (mult_a),
    .mult_b (mult_b),
    .add_c  (add_c),
    .busy   (busy),
    .valid  (valid),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // One full operation. Valid must be low through E0..E7 and high after E8.
  // The request is held for 'hold' extra cycles and then dropped.
  // With 'scramble' set, the operands change every CALC cycle.
  task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [15:0] exp,
                        input int hold, input bit scramble);
    mult_a = a;
    mult_b = b;
    add_c  = c;
    enable = 1'b1;
    step();
    check({name, "_busy_e0"}, busy, 1);
    check({name, "_valid_e0"}, valid, 0);
    for (int i = 1; i < 8; i++) begin
      if (scramble) begin
        mult_a = 8'($urandom);
        mult_b = 8'($urandom);
        add_c  = 8'($urandom);
      end
      step();
      if (i == 7) check({name, "_valid_e7"}, valid, 0);
    end
    step();
    check({name, "_valid_e8"}, valid, 1);
    check({name, "_busy_e8"}, busy, 1);
    check({name, "_result"}, result, exp);
    for (int h = 0; h < hold; h++) begin
      step();
      check({name, "_valid_hold"}, valid, 1);
      check({name, "_result_hold"}, result, exp);
    end
    enable = 1'b0;
    step();
    check({name, "_valid_drop"}, valid, 0);
    check({name, "_busy_drop"}, busy, 0);
    check({name, "_result_idle"}, result, exp);
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    mult_a = '0;
    mult_b = '0;
    add_c  = '0;
    step();
    step();
    check("reset_busy", busy, 0);
    check("reset_valid", valid, 0);
    check("reset_result", result, 0);
    reset = 1'b0;
    step();
    check("idle_no_enable_busy", busy, 0);

    run_op("basic",     8'd13,  8'd11,  8'd7,   16'd150,   0, 1'b0);
    run_op("max",       8'd255, 8'd255, 8'd255, 16'hFF00,  0, 1'b0);
    run_op("a_zero",    8'd0,   8'd200, 8'd5,   16'd5,     0, 1'b0);
    run_op("b_zero",    8'd100, 8'd0,   8'd9,   16'd9,     0, 1'b0);
    run_op("roundtrip", 8'd28,  8'd7,   8'd4,   16'd200,   0, 1'b0);
    run_op("hold5",     8'd255, 8'd1,   8'd0,   16'd255,   5, 1'b0);
    run_op("reraise",   8'd2,   8'd3,   8'd1,   16'd7,     0, 1'b0);
    run_op("scramble",  8'd37,  8'd129, 8'd200, 16'd4973,  0, 1'b1);

    // Reset during CALC cycle 4: the outputs clear at once, without waiting for a clock edge.
    mult_a = 8'd13;
    mult_b = 8'd11;
    add_c  = 8'd7;
    enable = 1'b1;
    step();
    for (int i = 0; i < 4; i++) step();
    check("pre_reset_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_valid", valid, 0);
    check("abort_result", result, 0);
    enable = 1'b0;
    step();
    reset = 1'b0;
    step();
    check("post_reset_idle", busy, 0);
    run_op("after_reset", 8'd3, 8'd4, 8'd0, 16'd12, 0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
